// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared state encoding and window constants for window_median
package median_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SORT    = 2'd1,
    OUT     = 2'd2
  } state_e;

  localparam int WIN_SIZE   = 9;
  localparam int MEDIAN_IDX = 4;
  localparam int LAST_PHASE = 8;

endpackage

// File: rtl/cmp_swap.sv
// rtl/cmp_swap.sv - combinational unsigned compare-swap, smaller value on lo
module cmp_swap #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] lo,
  output logic [PIX_W-1:0] hi
);

  logic swap;

  // Strict greater-than keeps equal values in place.
  assign swap = (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/window_median.sv
// rtl/window_median.sv - 3x3 window median via sequential odd-even transposition sort
module window_median
  import median_pkg::*;
#(
  parameter int               PIX_W     = 8,
  parameter logic [PIX_W-1:0] PAD_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_oob,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] median_out,
  output logic             median_valid,
  input  logic             median_ready,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       phase_q, phase_d;
  logic [PIX_W-1:0] median_q, median_d;
  logic [PIX_W-1:0] pix_q  [WIN_SIZE];
  logic [PIX_W-1:0] pix_d  [WIN_SIZE];
  logic [PIX_W-1:0] sorted [WIN_SIZE];

  logic [PIX_W-1:0] cs_a  [4];
  logic [PIX_W-1:0] cs_b  [4];
  logic [PIX_W-1:0] cs_lo [4];
  logic [PIX_W-1:0] cs_hi [4];
  logic             odd_phase;

  assign odd_phase = phase_q[0];

  // Even phases pair (0,1)..(6,7); odd phases pair (1,2)..(7,8).
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cs_a[k] = odd_phase ? pix_q[2*k+1] : pix_q[2*k];
      cs_b[k] = odd_phase ? pix_q[2*k+2] : pix_q[2*k+1];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cs
    cmp_swap #(.PIX_W(PIX_W)) u_cmp_swap (
      .a  (cs_a[g]),
      .b  (cs_b[g]),
      .lo (cs_lo[g]),
      .hi (cs_hi[g])
    );
  end

  always_comb begin
    sorted = pix_q;
    for (int k = 0; k < 4; k++) begin
      if (odd_phase) begin
        sorted[2*k+1] = cs_lo[k];
        sorted[2*k+2] = cs_hi[k];
      end else begin
        sorted[2*k]   = cs_lo[k];
        sorted[2*k+1] = cs_hi[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      phase_q  <= '0;
      median_q <= '0;
      for (int i = 0; i < WIN_SIZE; i++) begin
        pix_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      median_q <= median_d;
      pix_q    <= pix_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    median_d = median_q;
    pix_d    = pix_q;
    case (state_q)
      COLLECT: begin
        if (pix_valid) begin
          for (int i = 0; i < WIN_SIZE; i++) begin
            if (cnt_q == 4'(i)) begin
              pix_d[i] = pix_oob ? PAD_VALUE : pix_in;
            end
          end
          if (cnt_q == 4'(WIN_SIZE - 1)) begin
            cnt_d   = '0;
            phase_d = '0;
            state_d = SORT;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      SORT: begin
        pix_d = sorted;
        // The final phase's output is already fully sorted, so capture it directly.
        if (phase_q == 4'(LAST_PHASE)) begin
          median_d = sorted[MEDIAN_IDX];
          phase_d  = '0;
          state_d  = OUT;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      OUT: begin
        if (median_ready) begin
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_comb begin
    pix_ready    = (state_q == COLLECT);
    median_valid = (state_q == OUT);
    busy         = (state_q != COLLECT);
    median_out   = median_q;
  end

endmodule

// File: tb/tb_window_median.sv
// tb/tb_window_median.sv - directed and randomized self-checking bench for window_median
module tb_window_median;

  logic       clk;
  logic       reset;
  logic [7:0] pix_in;
  logic       pix_oob;
  logic       pix_valid;
  logic       median_ready;
  logic       pix_ready;
  logic [7:0] median_out;
  logic       median_valid;
  logic       busy;
  logic       pix_ready_p;
  logic [7:0] median_out_p;
  logic       median_valid_p;
  logic       busy_p;

  int checks;
  int errors;
  int beat_cnt;

  logic [7:0] win_val [9];
  logic       win_oob [9];

  window_median #(.PIX_W(8), .PAD_VALUE(8'd0)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .pix_in       (pix_in),
    .pix_oob      (pix_oob),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .median_out   (median_out),
    .median_valid (median_valid),
    .median_ready (median_ready),
    .busy         (busy)
  );

  window_median #(.PIX_W(8), .PAD_VALUE(8'd100)) u_dut_pad (
    .clk          (clk),
    .reset        (reset),
    .pix_in       (pix_in),
    .pix_oob      (pix_oob),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready_p),
    .median_out   (median_out_p),
    .median_valid (median_valid_p),
    .median_ready (median_ready),
    .busy         (busy_p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!reset && pix_valid && pix_ready) begin
      beat_cnt <= beat_cnt + 1;
    end
  end

  function automatic logic [7:0] model_median(input logic [7:0] pad);
    logic [7:0] v [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) begin
      v[i] = win_oob[i] ? pad : win_val[i];
    end
    for (int i = 1; i < 9; i++) begin
      for (int j = i; j > 0; j--) begin
        if (v[j-1] > v[j]) begin
          t = v[j]; v[j] = v[j-1]; v[j-1] = t;
        end
      end
    end
    return v[4];
  endfunction

  task automatic feed_window(input int nbeats, input int max_gap);
    int guard;
    int gap;
    for (int idx = 0; idx < nbeats; idx++) begin
      if (max_gap > 0) begin
        gap = $urandom_range(0, max_gap);
        for (int g = 0; g < gap; g++) begin
          pix_valid = 1'b0;
          @(negedge clk);
        end
      end
      pix_valid = 1'b1;
      pix_in    = win_val[idx];
      pix_oob   = win_oob[idx];
      guard     = 0;
      while (!pix_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) begin
        checks++;
        errors++;
        $display("FAIL feed_timeout: pix_ready=%0b after %0d cycles, required 1", pix_ready, guard);
        pix_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_median(output int lat);
    lat = 1;
    while (!median_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic clear_oob();
    for (int i = 0; i < 9; i++) win_oob[i] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1 || median_valid !== 1'b0 || median_out !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b out=%0d busy=%b, required 1 0 0 0",
               pix_ready, median_valid, median_out, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_descending();
    int lat;
    int b0;
    median_ready = 1'b1;
    win_val = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    clear_oob();
    b0 = beat_cnt;
    feed_window(9, 0);
    wait_median(lat);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL desc_latency: got %0d cycles, required 10", lat);
    end
    checks++;
    if (median_out !== 8'd5) begin
      errors++;
      $display("FAIL desc_median: got %0d, required 5", median_out);
    end
    @(negedge clk);
    checks++;
    if (median_valid !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL desc_one_cycle: valid=%b ready=%b, required 0 1", median_valid, pix_ready);
    end
    checks++;
    if (beat_cnt - b0 !== 9) begin
      errors++;
      $display("FAIL desc_beats: got %0d, required 9", beat_cnt - b0);
    end
  endtask

  task automatic test_duplicates();
    int lat;
    clear_oob();
    win_val = '{8'd10, 8'd10, 8'd10, 8'd200, 8'd200, 8'd0, 8'd0, 8'd0, 8'd10};
    feed_window(9, 0);
    wait_median(lat);
    checks++;
    if (lat !== 10 || median_out !== 8'd10) begin
      errors++;
      $display("FAIL dup_mixed: lat=%0d median=%0d, required 10 10", lat, median_out);
    end
    @(negedge clk);
    win_val = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
    feed_window(9, 0);
    wait_median(lat);
    checks++;
    if (lat !== 10 || median_out !== 8'd255) begin
      errors++;
      $display("FAIL dup_max: lat=%0d median=%0d, required 10 255", lat, median_out);
    end
    @(negedge clk);
  endtask

  task automatic test_oob_pad();
    int lat;
    win_val = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd50, 8'd60, 8'd7, 8'd70, 8'd80};
    win_oob = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    feed_window(9, 0);
    wait_median(lat);
    checks++;
    if (median_out !== 8'd0) begin
      errors++;
      $display("FAIL oob_pad0: got %0d, required 0", median_out);
    end
    checks++;
    if (median_valid_p !== 1'b1 || median_out_p !== 8'd100) begin
      errors++;
      $display("FAIL oob_pad100: valid=%b median=%0d, required 1 100", median_valid_p, median_out_p);
    end
    @(negedge clk);
    clear_oob();
  endtask

  task automatic test_backpressure();
    int lat;
    int b0;
    logic stable_ok;
    median_ready = 1'b0;
    win_val = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd5};
    clear_oob();
    feed_window(9, 0);
    wait_median(lat);
    checks++;
    if (lat !== 10 || median_out !== 8'd4) begin
      errors++;
      $display("FAIL bp_first: lat=%0d median=%0d, required 10 4", lat, median_out);
    end
    pix_valid = 1'b1;
    pix_in    = 8'd77;
    b0        = beat_cnt;
    stable_ok = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (median_valid !== 1'b1 || median_out !== 8'd4 || pix_ready !== 1'b0 || busy !== 1'b1) begin
        stable_ok = 1'b0;
      end
    end
    checks++;
    if (!stable_ok) begin
      errors++;
      $display("FAIL bp_hold: valid=%b median=%0d ready=%b, required 1 4 0", median_valid, median_out, pix_ready);
    end
    checks++;
    if (beat_cnt - b0 !== 0) begin
      errors++;
      $display("FAIL bp_no_beats: got %0d beats, required 0", beat_cnt - b0);
    end
    pix_valid    = 1'b0;
    median_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1 || median_valid !== 1'b0 || median_out !== 8'd4) begin
      errors++;
      $display("FAIL bp_release: ready=%b valid=%b median=%0d, required 1 0 4", pix_ready, median_valid, median_out);
    end
  endtask

  task automatic test_random();
    int lat;
    int b0;
    logic [7:0] exp0;
    logic [7:0] exp1;
    median_ready = 1'b1;
    for (int w = 0; w < 1000; w++) begin
      for (int i = 0; i < 9; i++) begin
        win_val[i] = 8'($urandom_range(0, 255));
        win_oob[i] = ($urandom_range(0, 7) == 0);
      end
      exp0 = model_median(8'd0);
      exp1 = model_median(8'd100);
      b0   = beat_cnt;
      feed_window(9, 5);
      wait_median(lat);
      checks++;
      if (lat !== 10 || median_out !== exp0 || median_out_p !== exp1) begin
        errors++;
        $display("FAIL rand_median w%0d: lat=%0d got %0d/%0d, required 10 %0d/%0d",
                 w, lat, median_out, median_out_p, exp0, exp1);
      end
      checks++;
      if (beat_cnt - b0 !== 9) begin
        errors++;
        $display("FAIL rand_beats w%0d: got %0d, required 9", w, beat_cnt - b0);
      end
      @(negedge clk);
    end
    clear_oob();
  endtask

  task automatic test_reset_midway();
    int lat;
    median_ready = 1'b1;
    clear_oob();
    for (int i = 0; i < 9; i++) win_val[i] = 8'd200;
    feed_window(5, 0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1 || median_valid !== 1'b0 || median_out !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_collect: ready=%b valid=%b out=%0d busy=%b, required 1 0 0 0",
               pix_ready, median_valid, median_out, busy);
    end
    reset = 1'b0;
    feed_window(9, 0);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_sort_busy: busy=%b, required 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1 || median_valid !== 1'b0 || median_out !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_sort: ready=%b valid=%b out=%0d busy=%b, required 1 0 0 0",
               pix_ready, median_valid, median_out, busy);
    end
    reset = 1'b0;
    win_val = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    feed_window(9, 0);
    wait_median(lat);
    checks++;
    if (lat !== 10 || median_out !== 8'd5) begin
      errors++;
      $display("FAIL rst_after: lat=%0d median=%0d, required 10 5", lat, median_out);
    end
    @(negedge clk);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    beat_cnt     = 0;
    reset        = 1'b1;
    pix_in       = 8'd0;
    pix_oob      = 1'b0;
    pix_valid    = 1'b0;
    median_ready = 1'b1;
    clear_oob();
    repeat (2) @(negedge clk);
    test_reset();
    test_descending();
    test_duplicates();
    test_oob_pad();
    test_backpressure();
    test_reset_midway();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
